// File: rtl/m_ext_pkg.sv
// rtl/m_ext_pkg.sv - shared RV32M definitions for the multiplier and divider
//   funct3 codes for MUL*/DIV*/REM*, divider FSM state encoding, iteration count.
package m_ext_pkg;

  // funct3 codes of the RV32M instructions
  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;

  // One quotient bit per CALC cycle
  localparam int DIV_ITER = 32;

  typedef enum logic [2:0] {
    DIV_IDLE = 3'd0,
    DIV_CALC = 3'd1,
    DIV_FIX  = 3'd2,
    DIV_DONE = 3'd3,
    DIV_HOLD = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - combinational single radix-2 restoring division step
//   rem_i/quo_i : current partial remainder and quotient/dividend shift register
//   dvsr_i      : divisor magnitude
//   rem_o/quo_o : values after one shift + trial subtract
module div_step #(
  parameter int size = 32
) (
  input  logic [size-1:0] rem_i,
  input  logic [size-1:0] quo_i,
  input  logic [size-1:0] dvsr_i,
  output logic [size-1:0] rem_o,
  output logic [size-1:0] quo_o
);

  logic [size:0] shifted_w;
  logic [size:0] diff_w;

  // rem < divisor always holds, so the shifted value is < 2*divisor and a
  // non-negative difference always fits in size bits; the top bit of the
  // size+1 bit difference is therefore a clean borrow flag.
  assign shifted_w = {rem_i, quo_i[size-1]};
  assign diff_w    = shifted_w - {1'b0, dvsr_i};

  always_comb begin
    if (diff_w[size]) begin
      rem_o = shifted_w[size-1:0];
      quo_o = {quo_i[size-2:0], 1'b0};
    end else begin
      rem_o = diff_w[size-1:0];
      quo_o = {quo_i[size-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div.sv
// rtl/div.sv - iterative RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per clock
//   clk, rst_n : clock, asynchronous active-low reset
//   op1, op2   : dividend, divisor (stable while start is high)
//   op         : funct3; 0xx codes divide as DIVU
//   start      : level request, held until done is seen
//   result     : quotient or remainder, held until next launch
//   done       : one-cycle completion pulse
module div
  import m_ext_pkg::*;
#(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [size-1:0] op1,
  input  logic [size-1:0] op2,
  input  logic [2:0]      op,
  input  logic            start,
  output logic [size-1:0] result,
  output logic            done
);

  localparam logic [5:0] CNT_LAST = 6'(DIV_ITER - 1);

  div_state_e      state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic            neg1_q, neg1_d;
  logic            neg2_q, neg2_d;
  logic [size-1:0] rem_q, rem_d;
  logic [size-1:0] quo_q, quo_d;
  logic [size-1:0] dvsr_q, dvsr_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [size-1:0] result_q, result_d;
  logic            done_q, done_d;

  // Launch-time decode of the live inputs
  logic            in_signed, in_rem, in_neg1, in_neg2, in_div0, in_ovf;
  logic [size-1:0] in_mag1, in_mag2;

  assign in_signed = op[2] & ~op[0];
  assign in_rem    = op[2] & op[1];
  assign in_neg1   = in_signed & op1[size-1];
  assign in_neg2   = in_signed & op2[size-1];
  assign in_mag1   = in_neg1 ? -op1 : op1;
  assign in_mag2   = in_neg2 ? -op2 : op2;
  assign in_div0   = (op2 == '0);
  assign in_ovf    = in_signed && (op1 == {1'b1, {(size-1){1'b0}}}) && (op2 == '1);

  // Decode of the latched operation for the sign fix-up
  logic q_rem;
  assign q_rem = op_q[2] & op_q[1];

  logic [size-1:0] step_rem, step_quo;

  div_step #(.size(size)) u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .quo_o  (step_quo)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;

    unique case (state_q)
      DIV_IDLE: begin
        if (start) begin
          op_d   = op;
          neg1_d = in_neg1;
          neg2_d = in_neg2;
          rem_d  = '0;
          quo_d  = in_mag1;
          dvsr_d = in_mag2;
          cnt_d  = '0;
          if (in_div0) begin
            result_d = in_rem ? op1 : '1;
            state_d  = DIV_DONE;
          end else if (in_ovf) begin
            // Quotient of the most-negative value by -1 wraps to itself
            result_d = in_rem ? '0 : op1;
            state_d  = DIV_DONE;
          end else begin
            state_d  = DIV_CALC;
          end
        end
      end

      DIV_CALC: begin
        if (!start) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == CNT_LAST) state_d = DIV_FIX;
        end
      end

      DIV_FIX: begin
        if (!start) begin
          state_d = DIV_IDLE;
        end else begin
          // neg flags are only ever set for signed ops
          if (q_rem) result_d = neg1_q ? -rem_q : rem_q;
          else       result_d = (neg1_q ^ neg2_q) ? -quo_q : quo_q;
          state_d = DIV_DONE;
        end
      end

      DIV_DONE: begin
        done_d  = 1'b1;
        state_d = DIV_HOLD;
      end

      DIV_HOLD: begin
        if (!start) state_d = DIV_IDLE;
      end

      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DIV_IDLE;
      op_q     <= '0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: doc/div.md
# div

Iterative 32-bit integer divider for the RV32M extension, the division counterpart to the pipelined multiplier. It sits beside the multiplier in the execute stage and implements DIV, DIVU, REM and REMU. It uses a radix-2 restoring algorithm, one quotient bit per clock. It shares the multiplier's start/done handshake so the core's M-unit sequencing is identical for both.

## Interface
- `size`, 32, operand/result width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op1`  in  size  dividend; must be held stable while `start` is high.
- `op2`  in  size  divisor; must be held stable while `start` is high.
- `op`  in  3  funct3 code: 100 DIV, 101 DIVU, 110 REM, 111 REMU. Codes 0xx behave as DIVU.
- `start`  in  1  level request; held high by the core until `done` is seen.
- `result`  out  size  quotient or remainder; registered; valid while `done` is high and held until the next launch.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, CALC, FIX, DONE, HOLD.
- IDLE with `start`=1: launch.
  - Latch `op`, the signs, and the operand magnitudes. Signed ops take the two's-complement magnitude of a negative operand; unsigned ops use raw values.
  - Clear remainder and counter.
  - Go to CALC, unless a special case applies (see below), in which case go to DONE.
- Special cases, detected at launch:
  - Divisor = 0: quotient = all ones, remainder = `op1`.
  - DIV/REM with `op1`=0x80000000 and `op2`=0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
  - In both cases `result` is loaded at the launch edge.
- CALC, 32 cycles, with a 6-bit counter running 0 to 31:
  - Shift {rem, quo} left by one.
  - Trial-subtract the divisor from rem (33-bit subtract).
  - If non-negative, rem gets the difference and quo LSB = 1.
  - Counter reaches 31: go to FIX.
- FIX: apply sign correction and load `result`.
  - DIV: negate quotient iff sign(op1) XOR sign(op2).
  - REM: negate remainder iff op1 is negative, so the remainder takes the dividend's sign.
  - Unsigned ops: no correction.
  - Go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to HOLD.
- HOLD: wait for `start`=0, then go to IDLE. This prevents relaunch on the same request.
- Abort: `start`=0 in CALC or FIX goes to IDLE. `done` is not asserted and `result` is unchanged.

## Timing
- Reset values: state IDLE, `done`=0, `result`=0, all internal registers 0.
- Normal latency: launch edge E0, CALC at E1–E32, FIX at E33, `done` high in the cycle following E34.
- Special-case latency: launch at E0 goes straight to DONE, so `done` is high in the cycle after E1 (the next cycle).
- `done` never exceeds one cycle per request.
- `result` is stable from the `done` cycle until the next launch edge.
- Asynchronous reset at any point, including mid-CALC, returns immediately to reset values. There is no completion pulse afterwards.
- `start` rising in HOLD is ignored; `start` must return low for at least one cycle between requests.
- Operand changes while `start` is high are a protocol violation. The latched copies are used.

## Structure
- Shared package `m_ext_pkg` holds:
  - funct3 constants: `INST_DIV`, `INST_DIVU`, `INST_REM`, `INST_REMU`, alongside the existing MUL codes.
  - The divider state encoding.
  - Constant `DIV_ITER`=32.
- Sub-module `div_step`: combinational single restoring step. It takes {rem, quo, divisor} and returns the next {rem, quo}, and keeps the datapath separate from control.
- All sign handling and special-case logic stays in `div`.

## Test plan
- DIVU 100/7: `result`=14 with `done` 35 cycles after `start` rises. REMU 100/7: `result`=2.
- DIV/REM signs:
  - DIV −7/2: 0xFFFFFFFD. REM −7/2: 0xFFFFFFFF.
  - DIV 7/−2: 0xFFFFFFFD. REM 7/−2: 1.
  - DIV −7/−2: 3.
- Divide by zero: DIVU 5/0 gives 0xFFFFFFFF and REMU 5/0 gives 5, each with `done` 2 cycles after `start`. DIV −1/0 gives 0xFFFFFFFF.
- Overflow: DIV 0x80000000/0xFFFFFFFF gives 0x80000000 and REM gives 0, with `done` 2 cycles after `start`.
- Abort and reset:
  - Drop `start` at cycle 10 of CALC: no `done`. The next DIVU 0xFFFFFFFF/0x10 is correct: 0x0FFFFFFF.
  - Assert `rst_n`=0 at cycle 20: `done`=0 and `result`=0 immediately.
- Held `start`: keep `start` high 50 cycles after DIVU 9/3. Exactly one `done` pulse, `result`=3 held throughout, and no relaunch until `start` falls.
